// File: rtl/sc_io_pkg.sv
// sc_io_pkg: shared constants, FSM state type and BCD helper for sc_io_unit.
package sc_io_pkg;

   // I/O word addresses (only addr[7:2] take part in decoding)
   localparam logic [7:0] ADDR_OUT0 = 8'h80;
   localparam logic [7:0] ADDR_OUT1 = 8'h84;
   localparam logic [7:0] ADDR_IN0  = 8'hC0;
   localparam logic [7:0] ADDR_IN1  = 8'hC4;
   localparam logic [7:0] ADDR_STAT = 8'hC8;

   // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // One double-dabble iteration on {bcd[11:0], bin[7:0]}:
   // add 3 to every BCD digit >= 5, then shift the whole word left by one.
   function automatic logic [19:0] dabble_step(input logic [19:0] v);
      logic [19:0] t;
      t = v;
      for (int unsigned i = 0; i < 3; i++) begin
         if (t[8 + 4*i +: 4] >= 4'd5)
            t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
      end
      return {t[18:0], 1'b0};
   endfunction

endpackage

// File: rtl/sc_io_sevenseg.sv
// sc_io_sevenseg: 4-bit BCD digit to active-low seven-segment pattern.
// Codes 10-15 are shown blank.
module sc_io_sevenseg
   import sc_io_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Digit decode table
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = SEG_ZERO;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sc_io_unit.sv
// sc_io_unit: memory-mapped I/O block for the single-cycle CPU.
// Two latched output words, two synchronized input words, a status word,
// and a decimal display of out_port0/1[7:0] on six seven-segment digits.
// Build option: define SC_IO_HEX_EN to include the binary-to-BCD conversion
// FSM and live hex outputs; without it hex0..5 are blank and io_busy is 0.
module sc_io_unit
   import sc_io_pkg::*;
(
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   input  logic        wmem,
   input  logic [31:0] in_port0,
   input  logic [31:0] in_port1,
   output logic [31:0] out_port0,
   output logic [31:0] out_port1,
   output logic [31:0] io_read_data,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic        io_busy
);

   logic [7:0]  word;
   logic        wr0, wr1;
   logic [31:0] sync0_a, sync0_b, sync1_a, sync1_b;
   logic [31:0] rd_d;
   logic        unused_addr;

   assign word        = {addr[7:2], 2'b00};
   assign unused_addr = ^{addr[31:8], addr[1:0]};
   assign wr0         = wmem && (word == ADDR_OUT0);
   assign wr1         = wmem && (word == ADDR_OUT1);

   // CPU stores to the output ports
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_port0 <= '0;
         out_port1 <= '0;
      end else begin
         if (wr0) out_port0 <= datain;
         if (wr1) out_port1 <= datain;
      end
   end

   // Two-flop synchronizers for the asynchronous input ports
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync0_a <= '0;
         sync0_b <= '0;
         sync1_a <= '0;
         sync1_b <= '0;
      end else begin
         sync0_a <= in_port0;
         sync0_b <= sync0_a;
         sync1_a <= in_port1;
         sync1_b <= sync1_a;
      end
   end

   // Read-data select; unmapped addresses return zero
   always_comb begin
      rd_d = '0;
      case (word)
         ADDR_IN0:  rd_d = sync0_b;
         ADDR_IN1:  rd_d = sync1_b;
         ADDR_STAT: rd_d = {31'b0, io_busy};
         default:   rd_d = '0;
      endcase
   end

   // Registered read data, updated every cycle
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) io_read_data <= '0;
      else         io_read_data <= rd_d;
   end

`ifdef SC_IO_HEX_EN
   state_t      state_q, state_d;
   logic        pend0, pend1;
   logic        take0, take1;
   logic        sel_q;
   logic [2:0]  cnt_q;
   logic [19:0] sr_q;
   logic [11:0] dig0_q, dig1_q;

   // Next-state logic; port0 has priority when both ports are pending
   always_comb begin
      state_d = state_q;
      take0   = 1'b0;
      take1   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend0) begin
               take0   = 1'b1;
               state_d = SHIFT;
            end else if (pend1) begin
               take1   = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT:   if (cnt_q == 3'd7) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Pending flags: a new write wins over the clear on conversion start,
   // so a write during a running conversion forces a reconversion.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pend0 <= 1'b0;
         pend1 <= 1'b0;
      end else begin
         if (wr0)        pend0 <= 1'b1;
         else if (take0) pend0 <= 1'b0;
         if (wr1)        pend1 <= 1'b1;
         else if (take1) pend1 <= 1'b0;
      end
   end

   // Conversion datapath: load, eight shift-add-3 steps, commit digits
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sel_q  <= 1'b0;
         cnt_q  <= '0;
         sr_q   <= '0;
         dig0_q <= '0;
         dig1_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (take0 || take1) begin
                  sel_q <= take1;
                  cnt_q <= '0;
                  sr_q  <= {12'b0, take1 ? out_port1[7:0] : out_port0[7:0]};
               end
            end
            SHIFT: begin
               sr_q  <= dabble_step(sr_q);
               cnt_q <= cnt_q + 3'd1;
            end
            DONE: begin
               if (sel_q) dig1_q <= sr_q[19:8];
               else       dig0_q <= sr_q[19:8];
            end
            default: ;
         endcase
      end
   end

   assign io_busy = pend0 || pend1 || (state_q != IDLE);

   sc_io_sevenseg u_seg0 (.bcd(dig0_q[3:0]),  .seg(hex0));
   sc_io_sevenseg u_seg1 (.bcd(dig0_q[7:4]),  .seg(hex1));
   sc_io_sevenseg u_seg2 (.bcd(dig0_q[11:8]), .seg(hex2));
   sc_io_sevenseg u_seg3 (.bcd(dig1_q[3:0]),  .seg(hex3));
   sc_io_sevenseg u_seg4 (.bcd(dig1_q[7:4]),  .seg(hex4));
   sc_io_sevenseg u_seg5 (.bcd(dig1_q[11:8]), .seg(hex5));
`else
   assign io_busy = 1'b0;
   assign hex0    = SEG_BLANK;
   assign hex1    = SEG_BLANK;
   assign hex2    = SEG_BLANK;
   assign hex3    = SEG_BLANK;
   assign hex4    = SEG_BLANK;
   assign hex5    = SEG_BLANK;
`endif

endmodule

// File: tb/tb_sc_io_unit.sv
// tb_sc_io_unit: directed, table-driven checks for sc_io_unit.
// Display expectations follow SC_IO_HEX_EN (blank digits and idle busy without it).
module tb_sc_io_unit;

`ifdef SC_IO_HEX_EN
   localparam bit HEX = 1'b1;
`else
   localparam bit HEX = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] addr, datain, in_port0, in_port1;
   logic        wmem;
   logic [31:0] out_port0, out_port1, io_read_data;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic        io_busy;

   int n_pass  = 0;
   int n_total = 0;

   sc_io_unit dut (
      .clock(clock), .resetn(resetn), .addr(addr), .datain(datain), .wmem(wmem),
      .in_port0(in_port0), .in_port1(in_port1),
      .out_port0(out_port0), .out_port1(out_port1), .io_read_data(io_read_data),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
      .io_busy(io_busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] erd;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected {hundreds, tens, ones} pattern for a displayed byte
   function automatic logic [20:0] digits(input int v);
      if (!HEX) return {3{7'b1111111}};
      return {seg(v / 100), seg((v / 10) % 10), seg(v % 10)};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr   = a;
      datain = d;
      wmem   = 1'b1;
      step();
      wmem   = 1'b0;
   endtask

   task automatic chk_p0(input string name, input int v);
      chk(name, {11'b0, hex2, hex1, hex0}, {11'b0, digits(v)});
   endtask

   task automatic chk_p1(input string name, input int v);
      chk(name, {11'b0, hex5, hex4, hex3}, {11'b0, digits(v)});
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      step();
   endtask

   initial begin
      resetn   = 1'b0;
      wmem     = 1'b0;
      addr     = '0;
      datain   = '0;
      in_port0 = 32'hA5A5_0001;
      in_port1 = 32'h0000_BEEF;

      // {w, addr, data, out_port0, out_port1, io_read_data}
      vt[0]  = '{1'b1, 32'h80, 32'h0000_0011, 32'h0000_0011, 32'h0,          32'h0};
      vt[1]  = '{1'b1, 32'h84, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022, 32'h0};
      vt[2]  = '{1'b1, 32'h40, 32'h0000_0123, 32'h0000_0011, 32'h0000_0022, 32'h0};
      vt[3]  = '{1'b1, 32'hC0, 32'h0000_0055, 32'h0000_0011, 32'h0000_0022, 32'hA5A5_0001};
      vt[4]  = '{1'b0, 32'hC0, 32'h0,          32'h0000_0011, 32'h0000_0022, 32'hA5A5_0001};
      vt[5]  = '{1'b0, 32'hC4, 32'h0,          32'h0000_0011, 32'h0000_0022, 32'h0000_BEEF};
      vt[6]  = '{1'b0, 32'hC7, 32'h0,          32'h0000_0011, 32'h0000_0022, 32'h0000_BEEF};
      vt[7]  = '{1'b0, 32'hCC, 32'h0,          32'h0000_0011, 32'h0000_0022, 32'h0};
      vt[8]  = '{1'b0, 32'h44, 32'h0,          32'h0000_0011, 32'h0000_0022, 32'h0};
      vt[9]  = '{1'b1, 32'h83, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0022, 32'h0};
      vt[10] = '{1'b0, 32'h00, 32'h0,          32'hDEAD_BEEF, 32'h0000_0022, 32'h0};
      vt[11] = '{1'b1, 32'h88, 32'h0000_0077, 32'hDEAD_BEEF, 32'h0000_0022, 32'h0};

      // Reset state
      step();
      step();
      chk("rst_out0", out_port0, 32'h0);
      chk("rst_out1", out_port1, 32'h0);
      chk("rst_rd", io_read_data, 32'h0);
      chk("rst_busy", {31'b0, io_busy}, 32'h0);
      chk_p0("rst_hex_p0", 0);
      chk_p1("rst_hex_p1", 0);
      resetn = 1'b1;
      step();
      step();
      step();

      // Table: register writes, decode and read mux
      for (int i = 0; i < 12; i++) begin
         addr   = vt[i].a;
         datain = vt[i].d;
         wmem   = vt[i].w;
         step();
         wmem   = 1'b0;
         chk($sformatf("vec%0d_out0", i), out_port0, vt[i].e0);
         chk($sformatf("vec%0d_out1", i), out_port1, vt[i].e1);
         chk($sformatf("vec%0d_rd", i), io_read_data, vt[i].erd);
      end
      for (int k = 0; k < 40; k++) step();
      chk_p0("tbl_hex_p0", 239);
      chk_p1("tbl_hex_p1", 34);
      chk("tbl_busy_idle", {31'b0, io_busy}, 32'h0);

      // 255 on port0: 10-cycle latency and busy window
      pulse_reset();
      wr(32'h80, 32'h0000_00FF);
      chk("p255_out0", out_port0, 32'h0000_00FF);
      chk("p255_busy_k0", {31'b0, io_busy}, {31'b0, HEX});
      for (int k = 1; k <= 10; k++) begin
         step();
         chk($sformatf("p255_busy_k%0d", k), {31'b0, io_busy}, {31'b0, HEX && (k <= 9)});
         chk_p0($sformatf("p255_hex_k%0d", k), (k >= 10) ? 255 : 0);
      end

      // Back-to-back stores to both ports
      pulse_reset();
      wr(32'h80, 32'd7);
      wr(32'h84, 32'd42);
      chk("b2b_busy_k1", {31'b0, io_busy}, {31'b0, HEX});
      for (int k = 2; k <= 20; k++) begin
         step();
         chk($sformatf("b2b_busy_k%0d", k), {31'b0, io_busy}, {31'b0, HEX && (k <= 19)});
         chk_p0($sformatf("b2b_p0_k%0d", k), (k >= 10) ? 7 : 0);
         chk_p1($sformatf("b2b_p1_k%0d", k), (k >= 20) ? 42 : 0);
      end

      // Rewrite of port0 during SHIFT forces a second conversion; status read
      wr(32'h80, 32'd1);
      step();
      step();
      step();
      wr(32'h80, 32'd99);
      addr = 32'hC8;
      for (int k = 5; k <= 20; k++) begin
         step();
         chk($sformatf("rew_busy_k%0d", k), {31'b0, io_busy}, {31'b0, HEX && (k <= 19)});
         chk_p0($sformatf("rew_p0_k%0d", k), (k >= 20) ? 99 : ((k >= 10) ? 1 : 7));
         if (k == 6) chk("rew_status_busy", io_read_data, {31'b0, HEX});
      end
      step();
      chk("rew_status_idle", io_read_data, 32'h0);

      // Input synchronizer latency
      addr = 32'hC4;
      step();
      chk("sync_old", io_read_data, 32'h0000_BEEF);
      in_port1 = 32'h0000_1234;
      step();
      chk("sync_e1", io_read_data, 32'h0000_BEEF);
      step();
      chk("sync_e2", io_read_data, 32'h0000_BEEF);
      step();
      chk("sync_e3", io_read_data, 32'h0000_1234);
      addr = 32'hCC;
      step();
      chk("unmapped_cc", io_read_data, 32'h0);

      // Reset mid-conversion aborts it and drops pending work
      wr(32'h80, 32'd200);
      step();
      step();
      step();
      step();
      chk("abort_busy_pre", {31'b0, io_busy}, {31'b0, HEX});
      resetn = 1'b0;
      #1;
      chk("abort_busy", {31'b0, io_busy}, 32'h0);
      chk_p0("abort_hex_p0", 0);
      chk_p1("abort_hex_p1", 0);
      chk("abort_out0", out_port0, 32'h0);
      chk("abort_out1", out_port1, 32'h0);
      chk("abort_rd", io_read_data, 32'h0);
      step();
      step();
      resetn = 1'b1;
      for (int k = 0; k < 12; k++) step();
      chk_p0("abort_after_p0", 0);
      chk("abort_after_busy", {31'b0, io_busy}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
